// File: rtl/s2p_pkg.sv
// Shared definitions for the serial_to_parallel deserializer.
// Holds the default word width (common with parallel_to_serial), the
// bit-order selector constants, the bit-counter width helper and the
// output-register state encoding.
package s2p_pkg;

  // Default word width, shared with the upstream parallel_to_serial.
  localparam int DEFAULT_WIDTH = 4;

  // Bit-order selectors for the MSB_FIRST parameter.
  localparam bit MSB_FIRST_C = 1'b1;
  localparam bit LSB_FIRST_C = 1'b0;

  // Width of the received-bit counter for a given word width.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Output register occupancy; FULL means p_data holds an undelivered word.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } s2p_state_e;

endpackage

// File: rtl/s2p_shift_reg.sv
// Parameterised shift register for serial_to_parallel.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   shift_en    - shift bit_in into the register on this edge
//   clr         - synchronous clear (wins over shift_en)
//   bit_in      - incoming serial bit
//   word_next   - register contents after shifting in bit_in; this is the
//                 completed word when bit_in is the last bit of a word
module s2p_shift_reg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word_next
);

  logic [WIDTH-1:0] shift_q;

  // MSB-first words grow from the right so the first bit ends up on top;
  // LSB-first words grow from the left so the first bit ends up at bit 0.
  generate
    if (MSB_FIRST) begin : g_msb
      assign word_next = {shift_q[WIDTH-2:0], bit_in};
    end else begin : g_lsb
      assign word_next = {bit_in, shift_q[WIDTH-1:1]};
    end
  endgenerate

  // Shift register; a clear re-frames the word and discards any bit
  // presented on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else if (clr) begin
      shift_q <= '0;
    end else if (shift_en) begin
      shift_q <= word_next;
    end
  end

endmodule

// File: rtl/serial_to_parallel.sv
// Deserializer downstream of parallel_to_serial.
// Samples s_data on each s_valid cycle, assembles WIDTH-bit words and
// presents them on a held p_data/p_valid output with a p_ready handshake.
// Ports:
//   clk, rst_n         - clock and asynchronous active-low reset
//   s_data, s_valid    - serial input stream
//   sync_clr           - synchronous re-framing clear of the partial word
//   p_data, p_valid    - held parallel output word and its valid flag
//   p_ready            - consumer accepts p_data at this edge
//   busy, bit_cnt      - partial word in progress / bits received so far
//   overrun, ovr_clr   - sticky dropped-word flag and its clear
module serial_to_parallel
  import s2p_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = MSB_FIRST_C
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_data,
  input  logic                        s_valid,
  input  logic                        sync_clr,
  output logic [WIDTH-1:0]            p_data,
  output logic                        p_valid,
  input  logic                        p_ready,
  output logic                        busy,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt,
  output logic                        overrun,
  input  logic                        ovr_clr
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  s2p_state_e       state_q, state_d;
  logic [CW-1:0]    bit_cnt_q;
  logic [WIDTH-1:0] p_data_q;
  logic [WIDTH-1:0] word_next;
  logic             overrun_q;
  logic             sample;
  logic             word_done;
  logic             accept;
  logic             load;
  logic             ovr_event;

  // A clear discards the bit on the same edge, so it also blocks completion.
  assign sample    = s_valid && !sync_clr;
  assign word_done = sample && (bit_cnt_q == CNT_LAST);
  assign accept    = p_valid && p_ready;
  assign load      = word_done && (!p_valid || p_ready);
  assign ovr_event = word_done && p_valid && !p_ready;

  s2p_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (sample),
    .clr       (sync_clr),
    .bit_in    (s_data),
    .word_next (word_next)
  );

  // Bit counter: wraps to zero on the edge that completes a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
    end else if (sync_clr) begin
      bit_cnt_q <= '0;
    end else if (sample) begin
      bit_cnt_q <= (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + CW'(1);
    end
  end

  // Output-register occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A full register empties only on an accept with no new word behind it;
  // completion without accept keeps it full and the new word is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (word_done) state_d = FULL;
      FULL:  if (accept && !word_done) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Parallel output word; only written when a completed word is loaded, so
  // it stays stable while waiting for the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_data_q <= '0;
    end else if (load) begin
      p_data_q <= word_next;
    end
  end

  // Sticky overrun flag; a new drop on the same edge as ovr_clr keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (ovr_event) begin
      overrun_q <= 1'b1;
    end else if (ovr_clr) begin
      overrun_q <= 1'b0;
    end
  end

  assign p_valid = (state_q == FULL);
  assign p_data  = p_data_q;
  assign bit_cnt = bit_cnt_q;
  assign busy    = (bit_cnt_q != '0);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench for serial_to_parallel. Two instances (MSB-first and
// LSB-first) share one stimulus stream; directed vectors come from a table
// and a randomized phase is checked against a queue-based word model.
module tb_serial_to_parallel;
  import s2p_pkg::*;

  localparam int W  = 4;
  localparam int CW = cnt_width(W);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_data = 1'b0;
  logic          s_valid = 1'b0;
  logic          sync_clr = 1'b0;
  logic          p_ready = 1'b0;
  logic          ovr_clr = 1'b0;

  logic [W-1:0]  p_data_m, p_data_l;
  logic          p_valid_m, p_valid_l;
  logic          busy_m, busy_l;
  logic [CW-1:0] bit_cnt_m, bit_cnt_l;
  logic          overrun_m, overrun_l;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_to_parallel #(.WIDTH(W), .MSB_FIRST(MSB_FIRST_C)) dut_msb (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .sync_clr (sync_clr),
    .p_data   (p_data_m),
    .p_valid  (p_valid_m),
    .p_ready  (p_ready),
    .busy     (busy_m),
    .bit_cnt  (bit_cnt_m),
    .overrun  (overrun_m),
    .ovr_clr  (ovr_clr)
  );

  serial_to_parallel #(.WIDTH(W), .MSB_FIRST(LSB_FIRST_C)) dut_lsb (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .sync_clr (sync_clr),
    .p_data   (p_data_l),
    .p_valid  (p_valid_l),
    .p_ready  (p_ready),
    .busy     (busy_l),
    .bit_cnt  (bit_cnt_l),
    .overrun  (overrun_l),
    .ovr_clr  (ovr_clr)
  );

  typedef struct {
    logic         sv, sd, clr, rdy, oclr;
    logic [W-1:0] pdm, pdl;
    logic         pv;
    int           cnt;
    logic         ovr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic sv, logic sd, logic clr, logic rdy, logic oclr,
                              logic [W-1:0] pdm, logic [W-1:0] pdl, logic pv,
                              int cnt, logic ovr);
    vec_t v;
    v.sv = sv; v.sd = sd; v.clr = clr; v.rdy = rdy; v.oclr = oclr;
    v.pdm = pdm; v.pdl = pdl; v.pv = pv; v.cnt = cnt; v.ovr = ovr;
    return v;
  endfunction

  // Reference model: bits of the current word in arrival order plus the
  // held output word for each bit order.
  bit         m_bits[$];
  logic [W-1:0] m_pdm, m_pdl;
  bit         m_pv, m_ovr;

  task automatic modelReset();
    m_bits.delete();
    m_pdm = '0; m_pdl = '0; m_pv = 0; m_ovr = 0;
  endtask

  task automatic modelStep(logic sv, logic sd, logic clr, logic rdy, logic oclr);
    bit done = 0;
    bit ovr_set = 0;
    int wm = 0, wl = 0;
    if (clr) begin
      m_bits.delete();
    end else if (sv) begin
      m_bits.push_back(sd);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) begin
          wm += int'(m_bits[i]) * (1 << (W - 1 - i));
          wl += int'(m_bits[i]) * (1 << i);
        end
        done = 1;
        m_bits.delete();
      end
    end
    if (done) begin
      if (!m_pv || rdy) begin
        m_pdm = W'(wm); m_pdl = W'(wl); m_pv = 1;
      end else begin
        ovr_set = 1;
      end
    end else if (m_pv && rdy) begin
      m_pv = 0;
    end
    if (ovr_set) m_ovr = 1;
    else if (oclr) m_ovr = 0;
  endtask

  task automatic compareField(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(string tag, logic [W-1:0] pdm, logic [W-1:0] pdl,
                             logic pv, int cnt, logic ovr);
    compareField({tag, " p_data msb"}, 32'(p_data_m), 32'(pdm));
    compareField({tag, " p_data lsb"}, 32'(p_data_l), 32'(pdl));
    compareField({tag, " p_valid msb"}, 32'(p_valid_m), 32'(pv));
    compareField({tag, " p_valid lsb"}, 32'(p_valid_l), 32'(pv));
    compareField({tag, " bit_cnt msb"}, 32'(bit_cnt_m), 32'(cnt));
    compareField({tag, " bit_cnt lsb"}, 32'(bit_cnt_l), 32'(cnt));
    compareField({tag, " busy msb"}, 32'(busy_m), 32'(cnt != 0));
    compareField({tag, " busy lsb"}, 32'(busy_l), 32'(cnt != 0));
    compareField({tag, " overrun msb"}, 32'(overrun_m), 32'(ovr));
    compareField({tag, " overrun lsb"}, 32'(overrun_l), 32'(ovr));
  endtask

  // Drive one cycle of inputs, let the edge happen, settle just after it.
  task automatic applyStimulus(logic sv, logic sd, logic clr, logic rdy, logic oclr);
    s_valid = sv; s_data = sd; sync_clr = clr; p_ready = rdy; ovr_clr = oclr;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    s_valid = 0; s_data = 0; sync_clr = 0; p_ready = 0; ovr_clr = 0;
    rst_n = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    modelReset();
  endtask

  initial begin
    // Reset and asynchronous mid-word reset.
    resetDut();
    checkOutput("reset", 4'h0, 4'h0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("pre async reset", 4'h0, 4'h0, 0, 2, 0);
    #2;
    rst_n = 0;
    #1;
    checkOutput("async reset", 4'h0, 4'h0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    applyStimulus(1, 1, 0, 1, 0);
    applyStimulus(1, 1, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("post reset word", 4'hC, 4'h3, 1, 0, 0);

    // Directed table: bit order, gaps, overrun, accept-with-load, sync_clr.
    resetDut();
    vecs.push_back(mk(1,1,0,1,0, 4'h0,4'h0,0,1,0));
    vecs.push_back(mk(1,0,0,1,0, 4'h0,4'h0,0,2,0));
    vecs.push_back(mk(1,1,0,1,0, 4'h0,4'h0,0,3,0));
    vecs.push_back(mk(1,0,0,1,0, 4'hA,4'h5,1,0,0));
    vecs.push_back(mk(0,0,0,1,0, 4'hA,4'h5,0,0,0));
    vecs.push_back(mk(0,0,0,1,0, 4'hA,4'h5,0,0,0));
    vecs.push_back(mk(1,1,0,1,0, 4'hA,4'h5,0,1,0));
    vecs.push_back(mk(0,0,0,1,0, 4'hA,4'h5,0,1,0));
    vecs.push_back(mk(1,1,0,1,0, 4'hA,4'h5,0,2,0));
    vecs.push_back(mk(0,0,0,1,0, 4'hA,4'h5,0,2,0));
    vecs.push_back(mk(1,1,0,1,0, 4'hA,4'h5,0,3,0));
    vecs.push_back(mk(0,0,0,1,0, 4'hA,4'h5,0,3,0));
    vecs.push_back(mk(1,1,0,1,0, 4'hF,4'hF,1,0,0));
    vecs.push_back(mk(0,0,0,1,0, 4'hF,4'hF,0,0,0));
    vecs.push_back(mk(1,1,0,0,0, 4'hF,4'hF,0,1,0));
    vecs.push_back(mk(1,1,0,0,0, 4'hF,4'hF,0,2,0));
    vecs.push_back(mk(1,1,0,0,0, 4'hF,4'hF,0,3,0));
    vecs.push_back(mk(1,1,0,0,0, 4'hF,4'hF,1,0,0));
    vecs.push_back(mk(1,0,0,0,0, 4'hF,4'hF,1,1,0));
    vecs.push_back(mk(1,1,0,0,0, 4'hF,4'hF,1,2,0));
    vecs.push_back(mk(1,0,0,0,0, 4'hF,4'hF,1,3,0));
    vecs.push_back(mk(1,1,0,0,1, 4'hF,4'hF,1,0,1));
    vecs.push_back(mk(0,0,0,0,0, 4'hF,4'hF,1,0,1));
    vecs.push_back(mk(0,0,0,1,0, 4'hF,4'hF,0,0,1));
    vecs.push_back(mk(0,0,0,0,1, 4'hF,4'hF,0,0,0));
    vecs.push_back(mk(1,1,0,0,0, 4'hF,4'hF,0,1,0));
    vecs.push_back(mk(1,0,0,0,0, 4'hF,4'hF,0,2,0));
    vecs.push_back(mk(1,0,0,0,0, 4'hF,4'hF,0,3,0));
    vecs.push_back(mk(1,1,0,0,0, 4'h9,4'h9,1,0,0));
    vecs.push_back(mk(1,0,0,0,0, 4'h9,4'h9,1,1,0));
    vecs.push_back(mk(1,0,0,0,0, 4'h9,4'h9,1,2,0));
    vecs.push_back(mk(1,1,0,0,0, 4'h9,4'h9,1,3,0));
    vecs.push_back(mk(1,1,0,1,0, 4'h3,4'hC,1,0,0));
    vecs.push_back(mk(0,0,0,1,0, 4'h3,4'hC,0,0,0));
    vecs.push_back(mk(1,1,0,1,0, 4'h3,4'hC,0,1,0));
    vecs.push_back(mk(1,1,0,1,0, 4'h3,4'hC,0,2,0));
    vecs.push_back(mk(1,1,1,1,0, 4'h3,4'hC,0,0,0));
    vecs.push_back(mk(1,0,0,1,0, 4'h3,4'hC,0,1,0));
    vecs.push_back(mk(1,1,0,1,0, 4'h3,4'hC,0,2,0));
    vecs.push_back(mk(1,1,0,1,0, 4'h3,4'hC,0,3,0));
    vecs.push_back(mk(1,0,0,1,0, 4'h6,4'h6,1,0,0));
    vecs.push_back(mk(0,0,0,1,0, 4'h6,4'h6,0,0,0));
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].sv, vecs[i].sd, vecs[i].clr, vecs[i].rdy, vecs[i].oclr);
      checkOutput($sformatf("vec%0d", i), vecs[i].pdm, vecs[i].pdl,
                  vecs[i].pv, vecs[i].cnt, vecs[i].ovr);
    end

    // Randomized phase against the reference model.
    resetDut();
    for (int n = 0; n < 600; n++) begin
      logic sv, sd, clr, rdy, oclr;
      sv   = ($urandom_range(0, 9) < 7);
      sd   = 1'($urandom);
      clr  = ($urandom_range(0, 19) == 0);
      rdy  = ($urandom_range(0, 9) < 4);
      oclr = ($urandom_range(0, 9) == 0);
      applyStimulus(sv, sd, clr, rdy, oclr);
      modelStep(sv, sd, clr, rdy, oclr);
      checkOutput($sformatf("rand%0d", n), m_pdm, m_pdl, m_pv, m_bits.size(), m_ovr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
Deserializer that sits directly downstream of parallel_to_serial. It samples the 1-bit serial stream on every cycle where the upstream valid is high, assembles WIDTH-bit words and presents each word on a held parallel output with a valid/ready handshake. It flags words it has to drop because of backpressure, and it can be re-framed by a synchronous clear.

Parameters:
WIDTH, 4, word width in bits; must be at least 2; matches the upstream parallel width.
MSB_FIRST, 1, 1 = first received bit lands in p_data[WIDTH-1]; 0 = first received bit lands in p_data[0].

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
s_data  input  1  serial data bit from the upstream s_data.
s_valid  input  1  s_data is valid this cycle; driven by the upstream valid.
sync_clr  input  1  synchronous clear of the partial word (re-framing).
p_data  output  WIDTH  assembled parallel word; held stable while p_valid=1.
p_valid  output  1  p_data holds an undelivered word.
p_ready  input  1  consumer accepts the word at this clock edge.
busy  output  1  a partial word is in progress (bit_cnt != 0).
bit_cnt  output  $clog2(WIDTH)  number of bits received so far in the current word.
overrun  output  1  sticky flag: a completed word was dropped.
ovr_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (rst_n=0, asynchronous): shift register=0, bit_cnt=0, p_data=0, p_valid=0, overrun=0, busy=0.
- Reset asserted mid-word discards the partial word and any held output word.
- Sampling: each edge with s_valid=1 and sync_clr=0 shifts s_data into the shift register.
  - MSB_FIRST=1: shift left, new bit enters at bit 0.
  - MSB_FIRST=0: shift right, new bit enters at bit WIDTH-1.
  - bit_cnt increments by 1.
- Idle cycles (s_valid=0) hold all state; gaps between bits are legal.
- Word completion: s_valid=1 while bit_cnt==WIDTH-1. The completed word is the shift register plus the current bit. bit_cnt wraps to 0 on the same edge.
- Output load: if p_valid==0, or p_valid&&p_ready on this edge, then p_data <= completed word and p_valid <= 1.
  - Latency: p_valid is high in the cycle after the edge that sampled the last bit.
- Overrun: if p_valid==1 and p_ready==0 on the completion edge, the completed word is dropped and overrun <= 1. p_data and p_valid are unchanged.
- Handshake:
  - The word transfers on an edge where p_valid&&p_ready. p_valid <= 0 unless a new word loads on the same edge.
  - p_data must not change while p_valid=1 and p_ready=0.
  - p_ready while p_valid=0 has no effect.
- sync_clr: bit_cnt <= 0 and shift register <= 0. p_data and p_valid are unaffected.
  - sync_clr with s_valid on the same edge: sync_clr wins and the bit is discarded.
- overrun is sticky until an edge with ovr_clr=1.
  - A new overrun event and ovr_clr on the same edge: overrun stays 1 (set wins).
- State machine, two states encoded by p_valid:
  - EMPTY goes to FULL on completion.
  - FULL goes to EMPTY on accept without completion.
  - FULL stays FULL on accept with completion, or on completion without accept (overrun).
- busy = (bit_cnt != 0), combinational from registered state.

Decomposition:
- Shared package s2p_pkg holds:
  - default WIDTH constant (4, shared with parallel_to_serial);
  - bit-order constants MSB_FIRST_C=1 and LSB_FIRST_C=0;
  - a count-width function returning $clog2(WIDTH).
- One sub-module: s2p_shift_reg, a parameterised WIDTH/MSB_FIRST shift register with shift enable and synchronous clear.
- The counter, output register, handshake and overrun logic stay in the top level.

Test Plan:
1. rst_n=0 for 2 cycles, then release; later feed bits 1,0 and drop rst_n asynchronously mid-word -> every output reads 0 immediately, and the next 4 bits form a clean word.
2. WIDTH=4, MSB_FIRST=1, p_ready=1, s_valid held high for bits 1,0,1,0 -> p_data=4'b1010; p_valid high for exactly one cycle, starting the cycle after the 4th bit; overrun=0.
3. MSB_FIRST=0, bits 1,0,1,0 -> p_data=4'b0101. Then bits 1,1,1,1 with one idle cycle between each bit -> p_data=4'b1111, and bit_cnt steps 1,2,3,0.
4. p_ready=0; send word 1111, then word 0101 -> p_data stays 4'b1111 and overrun=1. Raise p_ready for 1 cycle -> p_valid=0. Pulse ovr_clr -> overrun=0.
5. Hold p_valid=1 and pulse p_ready=1 on the same edge as the 4th bit of word 0011 -> p_data=4'b0011, p_valid stays 1, overrun stays 0.
6. Feed 2 bits, then sync_clr together with s_valid -> bit_cnt=0 and busy=0; the following bits 0,1,1,0 -> p_data=4'b0110.
